// File: rtl/core_pkg.sv
// Shared types for the core front end: prefetch FSM states, fetch entries, PC helpers.
package core_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    FULL  = 2'd2
  } prefetch_state_t;

  localparam logic [31:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/core_prefetch_fifo.sv
// DEPTH-entry synchronous FIFO of fetch entries with flush; pointers wrap mod DEPTH.
module core_prefetch_fifo
  import core_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  fetch_entry_t i_entry,
  input  logic         i_pop,
  input  logic         i_flush,
  output fetch_entry_t o_head,
  output logic [CW-1:0] o_count,
  output logic         o_empty,
  output logic         o_full
);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  // Flush drops everything queued; storage contents are left stale on purpose.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_entry;
  end

endmodule

// File: rtl/core_instr_prefetch.sv
// Instruction prefetch: sequential bus reads into a small FIFO, flushed on redirect.
// Optional CORE_PREFETCH_BYPASS_EN forwards a response straight to ID when the FIFO is empty.
module core_instr_prefetch
  import core_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_boot_addr,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_valid,
  output logic [31:0] o_pc,
  output logic [31:0] o_instr,
  input  logic        i_ready,
  output logic        o_rd_req,
  output logic [31:0] o_rd_addr,
  input  logic        i_rd_gnt,
  input  logic [31:0] i_rd_rdata
);

  localparam int CW = $clog2(DEPTH) + 1;

  prefetch_state_t r_state;
  prefetch_state_t w_next_state;
  logic [31:0]     r_fetch_pc;
  logic [31:0]     r_pending_pc;
  logic            r_inflight;

  fetch_entry_t    w_head;
  fetch_entry_t    w_resp_entry;
  logic [CW-1:0]   w_count;
  logic [CW-1:0]   w_occupancy;
  logic [CW-1:0]   w_next_occupancy;
  logic            w_empty;
  logic            w_full;
  logic            w_redirect;
  logic            w_req;
  logic            w_grant;
  logic            w_resp;
  logic            w_bypass;
  logic            w_pop_hs;
  logic            w_fifo_push;
  logic            w_fifo_pop;

  assign w_redirect   = i_redirect & (r_state != BOOT);
  assign w_occupancy  = w_count + CW'(r_inflight);
  assign w_req        = (r_state == FETCH) & (w_occupancy < CW'(DEPTH)) & ~i_redirect & ~rst;
  assign w_grant      = w_req & i_rd_gnt;
  assign w_resp       = r_inflight & ~w_redirect;
  assign w_resp_entry = '{pc: r_pending_pc, instr: i_rd_rdata};

`ifdef CORE_PREFETCH_BYPASS_EN
  assign w_bypass = w_resp & w_empty;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_pop_hs    = o_valid & i_ready;
  assign w_fifo_pop  = w_pop_hs & ~w_bypass;
  assign w_fifo_push = w_resp & ~(w_bypass & i_ready);

  assign w_next_occupancy = w_count + CW'(w_fifo_push & ~w_full) - CW'(w_fifo_pop & ~w_empty)
                          + CW'(w_grant);

  assign o_rd_req  = w_req;
  assign o_rd_addr = r_fetch_pc;

  always_comb begin
    o_valid = ~w_empty;
    o_pc    = w_empty ? 32'd0 : w_head.pc;
    o_instr = w_empty ? 32'd0 : w_head.instr;
    if (w_bypass) begin
      o_valid = 1'b1;
      o_pc    = r_pending_pc;
      o_instr = i_rd_rdata;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      BOOT:  w_next_state = FETCH;
      FETCH: begin
        if (!w_redirect && (w_next_occupancy == CW'(DEPTH))) w_next_state = FULL;
      end
      FULL: begin
        if (w_redirect || w_pop_hs) w_next_state = FETCH;
      end
      default: w_next_state = BOOT;
    endcase
  end

  // Redirect outranks a grant; BOOT ignores redirect and just latches the boot address.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= BOOT;
      r_fetch_pc   <= 32'd0;
      r_pending_pc <= 32'd0;
      r_inflight   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (r_state == BOOT) begin
        r_fetch_pc <= word_align(i_boot_addr);
        r_inflight <= 1'b0;
      end else if (w_redirect) begin
        r_fetch_pc <= word_align(i_redirect_pc);
        r_inflight <= 1'b0;
      end else if (w_grant) begin
        r_fetch_pc   <= r_fetch_pc + PC_STEP;
        r_pending_pc <= r_fetch_pc;
        r_inflight   <= 1'b1;
      end else begin
        r_inflight <= 1'b0;
      end
    end
  end

  core_prefetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .i_push (w_fifo_push),
    .i_entry(w_resp_entry),
    .i_pop  (w_fifo_pop),
    .i_flush(w_redirect),
    .o_head (w_head),
    .o_count(w_count),
    .o_empty(w_empty),
    .o_full (w_full)
  );

endmodule

// File: tb/tb_core_instr_prefetch.sv
// Scoreboard bench for core_instr_prefetch; bus returns addr ^ 0xA5A5A5A5 one cycle after grant.
module tb_core_instr_prefetch;

  logic        clk;
  logic        rst;
  logic [31:0] i_boot_addr;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        o_valid;
  logic [31:0] o_pc;
  logic [31:0] o_instr;
  logic        i_ready;
  logic        o_rd_req;
  logic [31:0] o_rd_addr;
  logic        i_rd_gnt;
  logic [31:0] i_rd_rdata;

  int          nChecks = 0;
  int          nFails  = 0;
  logic [63:0] expQ[$];
  logic [31:0] lastAddr = 32'd0;

`ifdef CORE_PREFETCH_BYPASS_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 3;
`endif

  core_instr_prefetch #(.DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_boot_addr  (i_boot_addr),
    .i_redirect   (i_redirect),
    .i_redirect_pc(i_redirect_pc),
    .o_valid      (o_valid),
    .o_pc         (o_pc),
    .o_instr      (o_instr),
    .i_ready      (i_ready),
    .o_rd_req     (o_rd_req),
    .o_rd_addr    (o_rd_addr),
    .i_rd_gnt     (i_rd_gnt),
    .i_rd_rdata   (i_rd_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (o_rd_req && i_rd_gnt) lastAddr <= o_rd_addr;
  assign i_rd_rdata = lastAddr ^ 32'hA5A5A5A5;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [31:0] boot, input logic redir,
                               input logic [31:0] rpc, input logic rdy, input logic gnt);
    rst           = r;
    i_boot_addr   = boot;
    i_redirect    = redir;
    i_redirect_pc = rpc;
    i_ready       = rdy;
    i_rd_gnt      = gnt;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut(input logic [31:0] boot, input logic rdy, input logic gnt);
    applyStimulus(1'b1, boot, 1'b0, 32'd0, rdy, gnt);
    nextCycle();
    applyStimulus(1'b0, boot, 1'b0, 32'd0, rdy, gnt);
    expQ.delete();
  endtask

  task automatic pushExp(input logic [31:0] pc, input logic [31:0] instr);
    expQ.push_back({pc, instr});
  endtask

  // Monitor: every accepted head entry is matched against the next expected entry.
  always @(negedge clk) begin
    if (!rst && o_valid && i_ready && expQ.size() > 0) begin
      logic [63:0] e;
      e = expQ.pop_front();
      checkOutput("head pc", o_pc, e[63:32]);
      checkOutput("head instr", o_instr, e[31:0]);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Boot and steady streaming
    applyStimulus(1'b1, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
    nextCycle();
    nextCycle();
    @(negedge clk);
    checkOutput("reset o_valid", 32'(o_valid), 32'd0);
    checkOutput("reset o_pc", o_pc, 32'd0);
    checkOutput("reset o_instr", o_instr, 32'd0);
    checkOutput("reset o_rd_req", 32'(o_rd_req), 32'd0);
    checkOutput("reset o_rd_addr", o_rd_addr, 32'd0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
    expQ.delete();
    pushExp(32'h0, 32'hA5A5A5A5);
    pushExp(32'h4, 32'hA5A5A5A1);
    pushExp(32'h8, 32'hA5A5A5AD);
    pushExp(32'hC, 32'hA5A5A5A9);
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      if (c == 0) checkOutput("boot no req", 32'(o_rd_req), 32'd0);
      if (c >= 1 && c <= 3) begin
        checkOutput("boot req", 32'(o_rd_req), 32'd1);
        checkOutput("boot addr", o_rd_addr, 32'(4 * (c - 1)));
      end
      checkOutput("boot valid timing", 32'(o_valid), (c >= LAT) ? 32'd1 : 32'd0);
      nextCycle();
    end
    checkOutput("boot drained", 32'(expQ.size()), 32'd0);

    // Backpressure fills the FIFO, then release
    resetDut(32'h0, 1'b0, 1'b1);
    pushExp(32'h0,  32'hA5A5A5A5);
    pushExp(32'h4,  32'hA5A5A5A1);
    pushExp(32'h8,  32'hA5A5A5AD);
    pushExp(32'hC,  32'hA5A5A5A9);
    pushExp(32'h10, 32'hA5A5A5B5);
    for (int c = 0; c <= 13; c++) begin
      if (c == 8) applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
      @(negedge clk);
      if (c >= 1 && c <= 4) begin
        checkOutput("bp req", 32'(o_rd_req), 32'd1);
        checkOutput("bp addr", o_rd_addr, 32'(4 * (c - 1)));
      end
      if (c >= 5 && c <= 8) checkOutput("bp stopped", 32'(o_rd_req), 32'd0);
      if (c == 5) begin
        checkOutput("bp valid", 32'(o_valid), 32'd1);
        checkOutput("bp head pc", o_pc, 32'h0);
      end
      if (c == 9) begin
        checkOutput("bp resume req", 32'(o_rd_req), 32'd1);
        checkOutput("bp resume addr", o_rd_addr, 32'h10);
      end
      nextCycle();
    end
    checkOutput("bp drained", 32'(expQ.size()), 32'd0);

    // Redirect while a response is in flight
    resetDut(32'h0, 1'b1, 1'b1);
    pushExp(32'h0,   32'hA5A5A5A5);
    pushExp(32'h4,   32'hA5A5A5A1);
    pushExp(32'h100, 32'hA5A5A4A5);
    pushExp(32'h104, 32'hA5A5A4A1);
    for (int c = 0; c <= 9; c++) begin
      if (c == 4) applyStimulus(1'b0, 32'h0, 1'b1, 32'h103, 1'b1, 1'b1);
      if (c == 5) applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
      @(negedge clk);
      if (c == 3) checkOutput("redir pre addr", o_rd_addr, 32'h8);
      if (c == 4) checkOutput("redir cycle req", 32'(o_rd_req), 32'd0);
      if (c == 5) begin
        checkOutput("redir new req", 32'(o_rd_req), 32'd1);
        checkOutput("redir new addr", o_rd_addr, 32'h100);
        checkOutput("redir flushed", 32'(o_valid), 32'd0);
      end
`ifdef CORE_PREFETCH_BYPASS_EN
      if (c == 6) checkOutput("redir bypass valid", 32'(o_valid), 32'd1);
`else
      if (c == 6) checkOutput("redir empty", 32'(o_valid), 32'd0);
`endif
      if (c == 7) checkOutput("redir target valid", 32'(o_valid), 32'd1);
      nextCycle();
    end
    checkOutput("redir drained", 32'(expQ.size()), 32'd0);

    // Grant stall holds the request
    resetDut(32'h20, 1'b1, 1'b0);
    pushExp(32'h20, 32'hA5A5A585);
    for (int c = 0; c <= 9; c++) begin
      if (c == 6) applyStimulus(1'b0, 32'h20, 1'b0, 32'h0, 1'b1, 1'b1);
      @(negedge clk);
      if (c >= 1 && c <= 6) begin
        checkOutput("stall req", 32'(o_rd_req), 32'd1);
        checkOutput("stall addr", o_rd_addr, 32'h20);
        checkOutput("stall no push", 32'(o_valid), 32'd0);
      end
      if (c == 5 + LAT) checkOutput("stall valid", 32'(o_valid), 32'd1);
      nextCycle();
    end
    checkOutput("stall drained", 32'(expQ.size()), 32'd0);

    // Address wrap, then reset with queued entries and a response in flight
    resetDut(32'hFFFF_FFFC, 1'b0, 1'b1);
    for (int c = 0; c <= 5; c++) begin
      if (c == 5) applyStimulus(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 1'b1);
      @(negedge clk);
      if (c == 1) checkOutput("wrap addr0", o_rd_addr, 32'hFFFF_FFFC);
      if (c == 2) checkOutput("wrap addr1", o_rd_addr, 32'h0);
      if (c == 3) checkOutput("wrap addr2", o_rd_addr, 32'h4);
      if (c == 5) checkOutput("prereset valid", 32'(o_valid), 32'd1);
      nextCycle();
    end
    applyStimulus(1'b0, 32'h40, 1'b0, 32'h0, 1'b1, 1'b1);
    expQ.delete();
    pushExp(32'h40, 32'hA5A5A5E5);
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      if (c == 0) begin
        checkOutput("postreset valid", 32'(o_valid), 32'd0);
        checkOutput("postreset pc", o_pc, 32'd0);
        checkOutput("postreset instr", o_instr, 32'd0);
      end
      if (c == 1) checkOutput("postreset addr", o_rd_addr, 32'h40);
      if (c == LAT) checkOutput("postreset first valid", 32'(o_valid), 32'd1);
      nextCycle();
    end
    checkOutput("postreset drained", 32'(expQ.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/core_instr_prefetch.md
# core_instr_prefetch

Instruction prefetch unit between the instruction-bus master port and the ID-stage PC/instruction register. It issues sequential word reads on the instruction bus and holds returned words with their PCs in a small FIFO. It presents them to ID with a valid/ready handshake and discards all queued and in-flight fetches on a control-flow redirect from ID (JAL) or EX (branch/JALR).

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- i_boot_addr  in  32  first fetch address after reset; sampled in BOOT
- i_redirect  in  1  flush and restart fetch at i_redirect_pc
- i_redirect_pc  in  32  redirect target; bits [1:0] ignored
- o_valid  out  1  head entry available
- o_pc  out  32  PC of head entry; 0 when empty
- o_instr  out  32  instruction of head entry; 0 when empty
- i_ready  in  1  ID consumes head when o_valid & i_ready
- o_rd_req  out  1  bus read request
- o_rd_addr  out  32  bus read address; [1:0] always 0
- i_rd_gnt  in  1  request accepted this cycle
- i_rd_rdata  in  32  read data, valid the cycle after a grant

## Operation
- States: BOOT, FETCH, FULL.
- BOOT: entered on rst.
  - o_rd_req=0.
  - fetch_pc <= {i_boot_addr[31:2],2'b00}.
  - Always goes to FETCH next cycle.
- FETCH: o_rd_req=1 and o_rd_addr=fetch_pc whenever count+inflight < DEPTH and ~i_redirect.
  - On grant: fetch_pc += 4 (wraps mod 2^32), inflight<=1, pending_pc<=fetch_pc. Otherwise inflight<=0.
  - Goes to FULL when count+inflight == DEPTH and no grant is possible.
- FULL: o_rd_req=0.
  - Returns to FETCH the cycle after a pop or redirect.
- Request stability: while o_rd_req=1 and i_rd_gnt=0, o_rd_addr holds.
- Response: when inflight=1, {pending_pc, i_rd_rdata} is pushed.
- Pop: occurs on o_valid & i_ready.
- Push and pop in the same cycle leave count unchanged.
- count never exceeds DEPTH; pushes never target a full FIFO because requests are gated by count+inflight.
- Redirect (highest priority, any state except BOOT):
  - count<=0, inflight<=0.
  - fetch_pc <= {i_redirect_pc[31:2],2'b00}.
  - o_rd_req=0 this cycle.
  - A response arriving in the redirect cycle is dropped.
  - A pop in the same cycle is still reported to ID; the discard is the consumer's concern.
- Redirect in BOOT is ignored.
- Reset mid-operation: all state cleared; any bus response in the following cycle is ignored.

## Timing
- Reset values:
  - o_valid=0, o_pc=0, o_instr=0, o_rd_req=0, o_rd_addr=0.
  - state=BOOT, count=0, inflight=0.
- First request: cycle 1 after rst deasserts (BOOT occupies cycle 0).
- Latency without bypass: grant at T, data at T+1, o_valid at T+2.
- Throughput: one word per cycle with continuous grant and ready.
- Redirect at T: first request for the new target at T+1.

## Configuration
- CORE_PREFETCH_BYPASS_EN defined:
  - When the FIFO is empty and a response arrives, o_valid/o_pc/o_instr are driven combinationally from pending_pc/i_rd_rdata in that cycle (o_valid at T+1).
  - If i_ready=1 the word is not written.
- Not defined: o_valid/o_pc/o_instr come only from FIFO storage; minimum latency T+2.

## Structure
- Shared package core_pkg:
  - typedef enum prefetch_state_t {BOOT, FETCH, FULL}.
  - localparam PC_STEP=4.
  - typedef struct fetch_entry_t {pc[31:0], instr[31:0]}.
- Sub-module core_prefetch_fifo:
  - DEPTH-entry synchronous FIFO of fetch_entry_t.
  - push/pop/flush, count output.
  - Read and write pointers wrap mod DEPTH.

## Test plan
- Boot: i_boot_addr=0x0000_0000, i_rd_gnt=1, i_ready=1, i_rd_rdata=addr^0xA5A5A5A5 → o_rd_addr 0x0,0x4,0x8 on consecutive cycles; first o_valid cycle 3 after reset release with o_pc=0x0, o_instr=0xA5A5A5A5; one entry per cycle thereafter.
- Backpressure: i_ready=0 → exactly 4 grants (0x0–0xC), then o_rd_req=0. Raise i_ready → pops 0x0,0x4,… and the next request is 0x10.
- Redirect with response in flight: grant at 0x8 at T, i_redirect=1, i_redirect_pc=0x103 at T+1 → 0x8 word never appears; o_rd_addr=0x100 at T+2; next o_pc=0x100.
- Grant stall: i_rd_gnt=0 for 5 cycles at fetch_pc=0x20 → o_rd_req=1, o_rd_addr=0x20 stable for all 5 cycles; no push.
- Wrap and reset: i_boot_addr=0xFFFF_FFFC → second fetch at 0x0000_0000. Assert rst for 1 cycle with 3 queued entries → o_valid=0 next cycle; the response from a pre-reset grant is dropped.
- Bypass (macro defined): empty FIFO, grant at T → o_valid=1 at T+1 with i_rd_rdata; with i_ready=1, count stays 0.
